real_div_seq: RTL and testbench

Sequential IEEE-754 floating-point divider; the inverse operation to the multiplier datapath in the real-arithmetic block set. It subtracts exponents and re-biases them, runs a radix-2 restoring mantissa division one quotient bit per cycle, then normalizes and rounds to nearest-even. Operands enter and results leave through valid/ready handshakes. Denormal inputs are treated as zero and denormal results are flushed to zero, matching the multiplier's exponent-range policy.

---
 rtl/real_div_seq_if.sv | 35 +++
 rtl/real_div_seq.sv | 214 +++++++++++++++++++++
 tb/tb_real_div_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/real_div_seq_if.sv
// rtl/real_div_seq_if.sv - operand/result handshake bundle for real_div_seq
// Purpose: groups the operand and result valid/ready channels and the exception flags.
// Ports (signals):
//   in_valid, in_ready          operand handshake
//   op1, op2                    dividend, divisor (WIDTH bits)
//   out_valid, out_ready        result handshake
//   res                         quotient op1/op2 (WIDTH bits)
//   div_by_zero, invalid, overflow, underflow, inexact   exception flags for res
// Modports: master drives operands and out_ready; slave is the divider.
interface real_div_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             div_by_zero;
    logic             invalid;
    logic             overflow;
    logic             underflow;
    logic             inexact;

    modport master (
        output in_valid, op1, op2, out_ready,
        input  in_ready, out_valid, res, div_by_zero, invalid, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, op1, op2, out_ready,
        output in_ready, out_valid, res, div_by_zero, invalid, overflow, underflow, inexact
    );
endinterface

// File: rtl/real_div_seq.sv
// rtl/real_div_seq.sv - sequential IEEE-754 divider, radix-2 restoring, round to nearest-even
// Purpose: res = op1 / op2 with one quotient bit per cycle; denormal inputs read as zero,
//          denormal results flush to zero.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     real_div_seq_if.slave: in_valid/in_ready/op1/op2 in, out_valid/out_ready/res/flags out
module real_div_seq #(
    parameter bit IS_DOUBLE  = 1'b0,
    parameter int WIDTH      = IS_DOUBLE ? 64 : 32,
    parameter int EXPONENT_W = IS_DOUBLE ? 11 : 8,
    parameter int MANTISSA_W = IS_DOUBLE ? 52 : 23
) (
    input  logic          clk,
    input  logic          rst_n,
    real_div_seq_if.slave bus
);
    localparam int N     = MANTISSA_W + 3;
    localparam int EW2   = EXPONENT_W + 2;
    localparam int CNT_W = $clog2(N);

    localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXPONENT_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXPONENT_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0]      QNAN     =
        {1'b0, {EXPONENT_W{1'b1}}, 1'b1, {(MANTISSA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EW2-1:0]   exp_q, exp_d;
    logic [MANTISSA_W+1:0]   rem_q, rem_d;
    logic [MANTISSA_W:0]     div_q, div_d;
    logic [N-1:0]            quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    dbz_q, dbz_d;
    logic                    inv_q, inv_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;

    // Operand field decode
    logic                  s1, s2, zero1, zero2, inf1, inf2, nan1, nan2, sign_in;
    logic [EXPONENT_W-1:0] e1, e2;
    logic [MANTISSA_W-1:0] f1, f2;

    assign s1      = bus.op1[WIDTH-1];
    assign s2      = bus.op2[WIDTH-1];
    assign e1      = bus.op1[WIDTH-2 -: EXPONENT_W];
    assign e2      = bus.op2[WIDTH-2 -: EXPONENT_W];
    assign f1      = bus.op1[MANTISSA_W-1:0];
    assign f2      = bus.op2[MANTISSA_W-1:0];
    assign sign_in = s1 ^ s2;
    // A zero exponent field is zero regardless of fraction (denormals read as zero)
    assign zero1   = (e1 == '0);
    assign zero2   = (e2 == '0);
    assign inf1    = (&e1) & ~(|f1);
    assign inf2    = (&e2) & ~(|f2);
    assign nan1    = (&e1) & (|f1);
    assign nan2    = (&e2) & (|f2);

    // Restoring division step: the remainder stays below 2*divisor, so it fits in M+2 bits
    logic [MANTISSA_W+1:0] div_ext, diff, rem_next;
    logic                  q_bit;

    assign div_ext  = {1'b0, div_q};
    assign q_bit    = (rem_q >= div_ext);
    assign diff     = rem_q - div_ext;
    assign rem_next = q_bit ? diff : rem_q;

    // Normalize and round. The quotient lies in (0.5, 2); when its MSB is clear the
    // implied one sits one bit lower, so every field moves down one position.
    logic                  norm, guard, low, sticky, round_up, carry, rnd_inexact;
    logic                  rnd_ovf, rnd_unf;
    logic [MANTISSA_W-1:0] frac_n;
    logic [MANTISSA_W:0]   mant_r;
    logic signed [EW2-1:0] exp_n, exp_r;

    assign norm        = quo_q[N-1];
    assign frac_n      = norm ? quo_q[N-2:2] : quo_q[N-3:1];
    assign guard       = norm ? quo_q[1] : quo_q[0];
    assign low         = norm & quo_q[0];
    assign sticky      = |rem_q;
    assign round_up    = guard & (low | sticky | frac_n[0]);
    // Carry out of the fraction means 1.11..1 rounded up to 2.0: fraction is already zero
    assign mant_r      = {1'b0, frac_n} + {{MANTISSA_W{1'b0}}, round_up};
    assign carry       = mant_r[MANTISSA_W];
    assign exp_n       = norm ? exp_q : exp_q - EXP_ONE;
    assign exp_r       = carry ? exp_n + EXP_ONE : exp_n;
    assign rnd_inexact = guard | low | sticky;
    assign rnd_ovf     = (exp_r >= EXP_MAX);
    assign rnd_unf     = (exp_r <= EXP_ZERO);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dbz_d   = dbz_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d = sign_in;
                    if (nan1 | nan2 | (zero1 & zero2) | (inf1 & inf2)) begin
                        state_d = S_DONE;
                        res_d   = QNAN;
                        {dbz_d, inv_d, ovf_d, unf_d, inx_d} = 5'b01000;
                    end else if (zero2 & ~inf1) begin
                        state_d = S_DONE;
                        res_d   = {sign_in, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
                        {dbz_d, inv_d, ovf_d, unf_d, inx_d} = 5'b10000;
                    end else if (inf1) begin
                        state_d = S_DONE;
                        res_d   = {sign_in, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
                        {dbz_d, inv_d, ovf_d, unf_d, inx_d} = 5'b00000;
                    end else if (zero1 | inf2) begin
                        state_d = S_DONE;
                        res_d   = {sign_in, {(WIDTH-1){1'b0}}};
                        {dbz_d, inv_d, ovf_d, unf_d, inx_d} = 5'b00000;
                    end else begin
                        state_d = S_DIVIDE;
                        exp_d   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;
                        rem_d   = {1'b0, 1'b1, f1};
                        div_d   = {1'b1, f2};
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_DIVIDE: begin
                quo_d = {quo_q[N-2:0], q_bit};
                rem_d = rem_next << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                dbz_d   = 1'b0;
                inv_d   = 1'b0;
                if (rnd_ovf) begin
                    res_d = {sign_q, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
                    {ovf_d, unf_d, inx_d} = 3'b101;
                end else if (rnd_unf) begin
                    res_d = {sign_q, {(WIDTH-1){1'b0}}};
                    {ovf_d, unf_d, inx_d} = 3'b011;
                end else begin
                    res_d = {sign_q, exp_r[EXPONENT_W-1:0], mant_r[MANTISSA_W-1:0]};
                    {ovf_d, unf_d, inx_d} = {2'b00, rnd_inexact};
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dbz_q   <= 1'b0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dbz_q   <= dbz_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.res         = res_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.invalid     = inv_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign bus.inexact     = inx_q;
endmodule

// File: tb/tb_real_div_seq.sv
// tb/tb_real_div_seq.sv - scoreboard bench for real_div_seq (binary32)
module tb_real_div_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    real_div_seq_if #(.WIDTH(32)) bus ();
    real_div_seq #(.IS_DOUBLE(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
        int          stall;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] cur_flags();
        return {bus.div_by_zero, bus.invalid, bus.overflow, bus.underflow, bus.inexact};
    endfunction

    // Reference: exact integer quotient with 40 extra bits, then round-to-nearest-even.
    // Flags order: {div_by_zero, invalid, overflow, underflow, inexact}.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] fl,
                                    output bit special);
        bit sa, sb, s, za, zb, ia, ib, na, nb;
        int ea, eb, e, sh;
        longint unsigned ma, mb, num, q, rem, low, half, mant;
        logic [31:0] inf_v, zero_v;
        sa = a[31]; sb = b[31]; s = sa ^ sb;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0); ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0); nb = (eb == 255) && (b[22:0] != 0);
        inf_v = {s, 8'hFF, 23'h0};
        zero_v = {s, 31'h0};
        fl = 5'b0;
        special = 1'b1;
        r = 32'h0;
        if (na || nb || (za && zb) || (ia && ib)) begin
            r = 32'h7FC00000; fl = 5'b01000;
        end else if (zb && !ia) begin
            r = inf_v; fl = 5'b10000;
        end else if (ia) begin
            r = inf_v;
        end else if (za || ib) begin
            r = zero_v;
        end else begin
            special = 1'b0;
            ma = 64'h800000 | longint'(a[22:0]);
            mb = 64'h800000 | longint'(b[22:0]);
            num = ma << 40;
            q = num / mb;
            rem = num % mb;
            e = ea - eb + 127;
            if (q >= (64'd1 << 40)) sh = 17;
            else begin sh = 16; e = e - 1; end
            mant = q >> sh;
            low = q & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (low > half || (low == half && (rem != 0 || (mant & 1) != 0))) mant = mant + 1;
            if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
            if (e >= 255) begin
                r = inf_v; fl = 5'b00101;
            end else if (e <= 0) begin
                r = zero_v; fl = 5'b00011;
            end else begin
                r = {s, 8'(e), 23'(mant)};
                fl = {4'b0, (low != 0) || (rem != 0)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int k;
        logic [7:0] e;
        logic [22:0] f;
        k = $urandom_range(0, 19);
        f = 23'($urandom);
        if (k == 0) e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else if (k == 2) begin e = 8'($urandom_range(1, 254)); f = 23'h0; end
        else if (k < 7) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, f};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic [4:0] ef, input int lat, input int stall);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: actual=0 required=1");
            return;
        end
        bus.op1 = a;
        bus.op2 = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.res = er; e.flags = ef; e.lat = lat; e.stall = stall; e.acc = cyc;
        exp_q.push_back(e);
        bus.in_valid = 1'b0;
        bus.op1 = $urandom;
        bus.op2 = $urandom;
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] r;
        logic [4:0]  fl;
        bit          sp;
        ref_div(a, b, r, fl, sp);
        issue(a, b, r, fl, sp ? 1 : 28, stall);
    endtask

    // Monitor: pops the scoreboard when a result appears, then exercises backpressure
    initial begin
        exp_t        e;
        logic [31:0] r0;
        logic [4:0]  f0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual=%0h required=none", bus.res);
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("res", bus.res, e.res);
                    check("flags", cur_flags(), e.flags);
                    check("latency", cyc - e.acc + 1, e.lat);
                    check("busy_in_ready", bus.in_ready, 1'b0);
                    r0 = bus.res;
                    f0 = cur_flags();
                    for (int i = 0; i < e.stall; i++) begin
                        @(negedge clk);
                        check("stall_out_valid", bus.out_valid, 1'b1);
                        check("stall_res", bus.res, r0);
                        check("stall_flags", cur_flags(), f0);
                        check("stall_in_ready", bus.in_ready, 1'b0);
                    end
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    check("post_hs_in_ready", bus.in_ready, 1'b1);
                    check("post_hs_out_valid", bus.out_valid, 1'b0);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.op1 = '0;
        bus.op2 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_res", bus.res, 32'h0);
        check("rst_flags", cur_flags(), 5'b0);
        rst_n = 1'b1;

        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 0);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 1);
        issue(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 28, 0);
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b10000, 1, 0);
        issue(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b01000, 1, 2);
        issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b01000, 1, 0);
        issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28, 0);
        issue(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28, 0);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 5);

        // Reset in the middle of a division
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", bus.out_valid, 1'b0);
        check("rst_mid_in_ready", bus.in_ready, 1'b1);
        check("rst_mid_res", bus.res, 32'h0);
        exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 0);

        for (int i = 0; i < 250; i++) begin
            issue_model(rand_op(), rand_op(), $urandom_range(0, 3));
        end

        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
